lc3_int_arbiter: RTL
====================

Name: lc3_int_arbiter

Overview:
- Parametrised LC-3 interrupt controller for N_SRC device sources.
- Each source has a programmable 3-bit priority; only winners whose priority exceeds the current processor priority are presented.
- Tracks each request with a REQ/ACK/SERVICE state machine and loads the 8-bit INTV/exception vector on ld_vector.
- Sits between the memory-mapped device status registers and the LC-3 control FSM.

Parameters:
- N_SRC, 4, number of interrupt sources (1..16); index 0 wins ties.
- IDW, 4, width of the source-id output; must satisfy 2^IDW >= N_SRC.
- BASE_VEC, 8'h02, device vector for source 0; source i vectors to BASE_VEC+i. BASE_VEC+N_SRC-1 must be <= 8'hFF.
- PRIV_VEC, 8'h00, privilege-exception vector.
- OPC_VEC, 8'h01, illegal-opcode exception vector.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- src_ready  in  N_SRC  per-source ready bit (status register bit 15).
- src_ie  in  N_SRC  per-source interrupt-enable bit (status register bit 14).
- src_prio  in  3*N_SRC  flattened priorities; bits [3i+2:3i] belong to source i; 0 disables the source.
- cpu_prio  in  3  current PSR priority, PSR[10:8].
- int_ack  in  1  one-cycle pulse from the control FSM accepting the interrupt.
- vector_mux  in  2  00 device, 01 privilege exception, 10/11 opcode exception.
- ld_vector  in  1  load enable for vector.
- int_req  out  1  interrupt request to the control FSM.
- int_priority  out  3  priority of the latched winner; 0 when idle.
- int_src_id  out  IDW  index of the latched winner.
- vector  out  8  registered vector.
- pending  out  N_SRC  combinational: src_ready & src_ie & (src_prio != 0).

Behaviour:
- Reset, synchronous: state=IDLE, int_req=0, int_priority=0, int_src_id=0, vector=8'h00. Reset overrides every other input in the same cycle, including int_ack and ld_vector, and aborts a REQ or SERVICE in progress.
- Arbitration is combinational.
  - Winner = pending source with the highest src_prio.
  - Ties go to the lowest index.
  - eligible = winner exists and winner priority > cpu_prio (strictly greater).
- State IDLE:
  - If eligible: latch winner id and priority, go to REQ.
  - int_req rises on the clock edge after the source becomes eligible (1-cycle latency).
  - int_ack in IDLE is ignored.
- State REQ:
  - int_req=1; int_priority and int_src_id show the latched winner.
  - Preemption: if the current winner's priority is strictly greater than the latched priority, re-latch the winner and stay in REQ. An equal-priority lower index does not preempt.
  - If the latched source stops pending, or its priority falls to <= cpu_prio, and int_ack is not asserted: go to IDLE; int_req falls the next cycle.
  - int_ack=1: go to SERVICE. int_ack takes precedence over preemption and withdrawal in the same cycle.
- State SERVICE:
  - int_req=0; int_priority and int_src_id hold.
  - Returns to IDLE the cycle after the latched source's pending bit clears (the ISR clears ready or ie).
  - Other sources are not arbitrated until the return to IDLE; nesting is not supported.
  - int_ack in SERVICE is ignored.
- Vector register, updated only when ld_vector=1, independent of state:
  - vector_mux=00: vector = BASE_VEC + int_src_id (8-bit add, no wrap possible by the parameter rule).
  - vector_mux=01: vector = PRIV_VEC.
  - vector_mux=10 or 11: vector = OPC_VEC.
  - ld_vector=1 with vector_mux=00 while IDLE loads BASE_VEC + the last latched id, which is 0 after reset. The output is never high-Z or X.
- ld_vector and int_ack in the same cycle: the vector uses the int_src_id value from before the edge, which is the latched winner.
- cpu_prio changes while in REQ take effect in the same cycle through the withdrawal rule above.

Test Plan:
- Reset, then source 0 with ready=ie=1, prio=4, cpu_prio=0 -> int_req=1 one cycle later; int_priority=4; int_src_id=0. Send int_ack, then ld_vector with mux=00 -> vector=8'h02.
- Sources 1 and 2 both pending at prio=3, cpu_prio=1 -> int_src_id=1. After ack and ld_vector -> vector=8'h03.
- In REQ latched on source 2 at prio=2, source 3 becomes pending at prio=6 -> next cycle int_src_id=3, int_priority=6. Ack and load -> vector=8'h05.
- Source 0 pending at prio=3 with cpu_prio=3 -> int_req stays 0. Change cpu_prio to 2 -> int_req=1 the next cycle.
- In REQ, source drops ready before ack -> int_req=0 and int_priority=0 the next cycle. In SERVICE, a higher-priority source arrives -> int_req stays 0 until the serviced source clears, then rises one cycle after IDLE.
- With ld_vector=1: mux=01 -> vector=8'h00; mux=11 -> vector=8'h01. Assert rst together with int_ack in REQ -> int_req=0, vector=8'h00, state IDLE.

Source files
------------

// File: rtl/lc3_int_arbiter_if.sv
// Bus between the LC-3 interrupt arbiter and its surroundings (device status
// registers, PSR and control FSM).
//   master : drives device status, priorities, cpu_prio, int_ack, vector load
//   slave  : the arbiter; drives int_req, winner info, vector, pending
interface lc3_int_arbiter_if #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned IDW   = 4
);
  logic [N_SRC-1:0]   src_ready;
  logic [N_SRC-1:0]   src_ie;
  logic [3*N_SRC-1:0] src_prio;
  logic [2:0]         cpu_prio;
  logic               int_ack;
  logic [1:0]         vector_mux;
  logic               ld_vector;
  logic               int_req;
  logic [2:0]         int_priority;
  logic [IDW-1:0]     int_src_id;
  logic [7:0]         vector;
  logic [N_SRC-1:0]   pending;

  modport master (
    output src_ready, src_ie, src_prio, cpu_prio, int_ack, vector_mux, ld_vector,
    input  int_req, int_priority, int_src_id, vector, pending
  );

  modport slave (
    input  src_ready, src_ie, src_prio, cpu_prio, int_ack, vector_mux, ld_vector,
    output int_req, int_priority, int_src_id, vector, pending
  );
endinterface

// File: rtl/lc3_int_arbiter.sv
// LC-3 interrupt arbiter for N_SRC device sources.
// Picks the highest-priority pending source (lowest index on ties), requests
// the control FSM when it beats the PSR priority, tracks REQ/ACK/SERVICE and
// holds the 8-bit INTV / exception vector register.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : lc3_int_arbiter_if slave modport (status inputs, handshake, vector)
// Parameter rules assumed by the design: 2**IDW >= N_SRC, BASE_VEC+N_SRC-1 <= 8'hFF.
module lc3_int_arbiter #(
  parameter int unsigned N_SRC    = 4,
  parameter int unsigned IDW      = 4,
  parameter logic [7:0]  BASE_VEC = 8'h02,
  parameter logic [7:0]  PRIV_VEC = 8'h00,
  parameter logic [7:0]  OPC_VEC  = 8'h01
) (
  input logic               clk,
  input logic               rst,
  lc3_int_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic [2:0]     prio_q, prio_d;
  logic [7:0]     vector_q, vector_d;

  logic [N_SRC-1:0] pend;
  logic [2:0]       win_prio;
  logic [IDW-1:0]   win_id;
  logic             eligible;
  logic             lat_pend;
  logic [2:0]       lat_prio;

  // Pending sources and the combinational winner. Strict '>' keeps the lowest
  // index on ties; a pending source always has nonzero priority, so
  // win_prio == 0 means no winner.
  always_comb begin
    pend     = '0;
    win_prio = '0;
    win_id   = '0;
    lat_pend = 1'b0;
    lat_prio = '0;
    for (int i = 0; i < N_SRC; i++) begin
      pend[i] = bus.src_ready[i] & bus.src_ie[i] & (bus.src_prio[3*i +: 3] != 3'd0);
      if (pend[i] && (bus.src_prio[3*i +: 3] > win_prio)) begin
        win_prio = bus.src_prio[3*i +: 3];
        win_id   = IDW'(i);
      end
      if (id_q == IDW'(i)) begin
        lat_pend = pend[i];
        lat_prio = bus.src_prio[3*i +: 3];
      end
    end
    eligible = (win_prio != 3'd0) && (win_prio > bus.cpu_prio);
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    prio_d  = prio_q;
    unique case (state_q)
      StIdle: begin
        if (eligible) begin
          state_d = StReq;
          id_d    = win_id;
          prio_d  = win_prio;
        end
      end
      StReq: begin
        if (bus.int_ack) begin
          state_d = StService;
        end else if (!lat_pend || (lat_prio <= bus.cpu_prio)) begin
          // Withdrawn: id is kept so an idle vector load sees the last winner.
          state_d = StIdle;
          prio_d  = 3'd0;
        end else if (win_prio > prio_q) begin
          id_d   = win_id;
          prio_d = win_prio;
        end
      end
      StService: begin
        if (!lat_pend) begin
          state_d = StIdle;
          prio_d  = 3'd0;
        end
      end
      default: begin
        state_d = StIdle;
        prio_d  = 3'd0;
      end
    endcase
  end

  // Uses id_q from before the edge, so a load coincident with int_ack sees
  // the latched winner.
  always_comb begin
    vector_d = vector_q;
    if (bus.ld_vector) begin
      unique case (bus.vector_mux)
        2'b00:   vector_d = BASE_VEC + 8'(id_q);
        2'b01:   vector_d = PRIV_VEC;
        default: vector_d = OPC_VEC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      id_q     <= '0;
      prio_q   <= '0;
      vector_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      prio_q   <= prio_d;
      vector_q <= vector_d;
    end
  end

  assign bus.pending      = pend;
  assign bus.int_req      = (state_q == StReq);
  assign bus.int_priority = prio_q;
  assign bus.int_src_id   = id_q;
  assign bus.vector       = vector_q;

endmodule
